lsu: RTL and testbench

Load/store unit for the RV32I core: the initiator on the core side of the word-wide data memory port. It accepts one load or store per handshake from the execute stage and drives the memory's separate read and write ports. It performs sign/zero extension for loads and read-modify-write for byte/halfword stores, because the memory has no byte enables. It returns one response per request with read data or an error flag.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_align.sv | 63 ++++++
 rtl/lsu.sv | 157 +++++++++++++++
 tb/tb_lsu.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit.
// Holds funct3 encodings, FSM state encoding, datapath widths and a
// funct3 legality helper used at request accept.
package lsu_pkg;

    localparam int XLEN     = 32;
    localparam int F3_WIDTH = 3;
    localparam int IDX_W    = XLEN - 2;

    localparam logic [F3_WIDTH-1:0] F3_B  = 3'd0;
    localparam logic [F3_WIDTH-1:0] F3_H  = 3'd1;
    localparam logic [F3_WIDTH-1:0] F3_W  = 3'd2;
    localparam logic [F3_WIDTH-1:0] F3_BU = 3'd4;
    localparam logic [F3_WIDTH-1:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // Stores only have signed-looking encodings; BU/HU exist for loads only.
    function automatic logic f3_valid(input logic we, input logic [F3_WIDTH-1:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: load lane extract with sign/zero
// extension, and store lane merge into the previously read word.
// Ports: old_word_in (memory word), wdata_in (store data), addr_lo_in
// (byte offset), funct3_in (size/signedness) -> load_data_out, merge_data_out.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0]     old_word_in,
    input  logic [XLEN-1:0]     wdata_in,
    input  logic [1:0]          addr_lo_in,
    input  logic [F3_WIDTH-1:0] funct3_in,
    output logic [XLEN-1:0]     load_data_out,
    output logic [XLEN-1:0]     merge_data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_unsigned;

    assign is_unsigned = funct3_in[2];

    always_comb begin
        byte_sel = old_word_in[7:0];
        case (addr_lo_in)
            2'd1:    byte_sel = old_word_in[15:8];
            2'd2:    byte_sel = old_word_in[23:16];
            2'd3:    byte_sel = old_word_in[31:24];
            default: byte_sel = old_word_in[7:0];
        endcase
        // addr[0] is ignored for halfwords; misalignment is screened upstream.
        half_sel = addr_lo_in[1] ? old_word_in[31:16] : old_word_in[15:0];
    end

    always_comb begin
        load_data_out = old_word_in;
        case (funct3_in[1:0])
            2'd0:    load_data_out = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            2'd1:    load_data_out = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: load_data_out = old_word_in;
        endcase
    end

    always_comb begin
        merge_data_out = wdata_in;
        case (funct3_in[1:0])
            2'd0: begin
                merge_data_out = old_word_in;
                case (addr_lo_in)
                    2'd1:    merge_data_out[15:8]  = wdata_in[7:0];
                    2'd2:    merge_data_out[23:16] = wdata_in[7:0];
                    2'd3:    merge_data_out[31:24] = wdata_in[7:0];
                    default: merge_data_out[7:0]   = wdata_in[7:0];
                endcase
            end
            2'd1: begin
                merge_data_out = addr_lo_in[1] ? {wdata_in[15:0], old_word_in[15:0]}
                                               : {old_word_in[31:16], wdata_in[15:0]};
            end
            default: merge_data_out = wdata_in;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: accepts one load/store per handshake, drives a
// word-wide memory with combinational read and edge-committed write, does
// read-modify-write for SB/SH, returns one response (data or error) per request.
// Ports: clkin/nrst_in; req_* (valid/ready request); resp_* (one-cycle response);
// mem_rd_* (combinational read port); mem_wr_* (write port).
// Optional: define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic                clkin,
    input  logic                nrst_in,
    input  logic                req_valid_in,
    output logic                req_ready_out,
    input  logic                req_we_in,
    input  logic [F3_WIDTH-1:0] req_funct3_in,
    input  logic [XLEN-1:0]     req_addr_in,
    input  logic [XLEN-1:0]     req_wdata_in,
    output logic                resp_valid_out,
    output logic [XLEN-1:0]     resp_rdata_out,
    output logic                resp_err_out,
    output logic [XLEN-1:0]     mem_rd_addr_out,
    input  logic [XLEN-1:0]     mem_rd_data_in,
    output logic                mem_wr_en_out,
    output logic [XLEN-1:0]     mem_wr_addr_out,
    output logic [XLEN-1:0]     mem_wr_data_out
);

    lsu_state_t          state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [1:0]          lane_q;
    logic [F3_WIDTH-1:0] f3_q;
    logic                we_q;
    logic [XLEN-1:0]     wdata_q;
    logic                ready_q;
    logic                resp_valid_q;
    logic [XLEN-1:0]     resp_rdata_q;
    logic                resp_err_q;
    logic                wr_en_q;
    logic [XLEN-1:0]     wr_data_q;

    logic [XLEN-1:0]     load_data;
    logic [XLEN-1:0]     merge_data;
    logic                idx_oob;
    logic                misalign;
    logic                req_err;
    logic                accept;

    lsu_align u_align (
        .old_word_in    (mem_rd_data_in),
        .wdata_in       (wdata_q),
        .addr_lo_in     (lane_q),
        .funct3_in      (f3_q),
        .load_data_out  (load_data),
        .merge_data_out (merge_data)
    );

    assign idx_oob = (req_addr_in[XLEN-1:2] >= IDX_W'(MEM_WORDS));

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        case (req_funct3_in)
            F3_H, F3_HU: misalign = req_addr_in[0];
            F3_W:        misalign = |req_addr_in[1:0];
            default:     misalign = 1'b0;
        endcase
    end
`else
    // Low address bits below the access size are simply dropped.
    assign misalign = 1'b0;
`endif

    assign req_err = ~f3_valid(req_we_in, req_funct3_in) | idx_oob | misalign;
    assign accept  = req_valid_in & ready_q;

    always_ff @(posedge clkin or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            lane_q       <= '0;
            f3_q         <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
        end else begin
            // Strobes are single-cycle unless re-armed by a transition below.
            resp_valid_q <= 1'b0;
            wr_en_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        idx_q   <= req_addr_in[XLEN-1:2];
                        lane_q  <= req_addr_in[1:0];
                        f3_q    <= req_funct3_in;
                        we_q    <= req_we_in;
                        wdata_q <= req_wdata_in;
                        ready_q <= 1'b0;
                        if (req_err) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (req_we_in && (req_funct3_in == F3_W)) begin
                            // Full-word store needs no old data.
                            state_q   <= ST_WRITE;
                            wr_en_q   <= 1'b1;
                            wr_data_q <= req_wdata_in;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (we_q) begin
                        state_q   <= ST_WRITE;
                        wr_en_q   <= 1'b1;
                        wr_data_q <= merge_data;
                    end else begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_data;
                    end
                end
                ST_WRITE: begin
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    ready_q      <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
            endcase
        end
    end

    assign req_ready_out   = ready_q;
    assign resp_valid_out  = resp_valid_q;
    assign resp_rdata_out  = resp_rdata_q;
    assign resp_err_out    = resp_err_q;
    assign mem_rd_addr_out = {2'b00, idx_q};
    assign mem_wr_addr_out = {2'b00, idx_q};
    assign mem_wr_en_out   = wr_en_q;
    assign mem_wr_data_out = wr_data_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clkin = 1'b0;
    logic        nrst_in;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_we_in;
    logic [2:0]  req_funct3_in;
    logic [31:0] req_addr_in;
    logic [31:0] req_wdata_in;
    logic        resp_valid_out;
    logic [31:0] resp_rdata_out;
    logic        resp_err_out;
    logic [31:0] mem_rd_addr_out;
    logic [31:0] mem_rd_data_in;
    logic        mem_wr_en_out;
    logic [31:0] mem_wr_addr_out;
    logic [31:0] mem_wr_data_out;

    logic [31:0] tb_mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clkin = ~clkin;

    lsu #(.MEM_WORDS(256)) dut (
        .clkin           (clkin),
        .nrst_in         (nrst_in),
        .req_valid_in    (req_valid_in),
        .req_ready_out   (req_ready_out),
        .req_we_in       (req_we_in),
        .req_funct3_in   (req_funct3_in),
        .req_addr_in     (req_addr_in),
        .req_wdata_in    (req_wdata_in),
        .resp_valid_out  (resp_valid_out),
        .resp_rdata_out  (resp_rdata_out),
        .resp_err_out    (resp_err_out),
        .mem_rd_addr_out (mem_rd_addr_out),
        .mem_rd_data_in  (mem_rd_data_in),
        .mem_wr_en_out   (mem_wr_en_out),
        .mem_wr_addr_out (mem_wr_addr_out),
        .mem_wr_data_out (mem_wr_data_out)
    );

    assign mem_rd_data_in = (mem_rd_addr_out < 32'd256) ? tb_mem[mem_rd_addr_out[7:0]] : 32'h0;

    always @(posedge clkin) begin
        if (mem_wr_en_out && mem_wr_addr_out < 32'd256)
            tb_mem[mem_wr_addr_out[7:0]] <= mem_wr_data_out;
    end

    // Issues one request and observes it to completion. lat = sample index
    // (1 = first cycle after accept edge) where resp_valid_out was seen, 0 on timeout.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                          output logic err, output int wr_cnt, output int wr_first,
                          output logic [31:0] wa, output logic [31:0] wd,
                          output logic vld_after, output logic rdy_after);
        lat = 0; rdata = 'x; err = 1'bx; wr_cnt = 0; wr_first = 0; wa = 'x; wd = 'x;
        @(negedge clkin);
        req_valid_in = 1'b1; req_we_in = we; req_funct3_in = f3;
        req_addr_in = addr; req_wdata_in = wdata;
        @(posedge clkin); #1;
        req_valid_in = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (mem_wr_en_out) begin
                wr_cnt++;
                if (wr_first == 0) wr_first = n;
                wa = mem_wr_addr_out; wd = mem_wr_data_out;
            end
            if (resp_valid_out) begin
                lat = n; rdata = resp_rdata_out; err = resp_err_out;
                break;
            end
            @(posedge clkin); #1;
        end
        @(posedge clkin); #1;
        vld_after = resp_valid_out;
        rdy_after = req_ready_out;
    endtask

    task automatic test_reset();
        nrst_in = 1'b0;
        req_valid_in = 1'b1; req_we_in = 1'b1; req_funct3_in = 3'd2;
        req_addr_in = 32'h10; req_wdata_in = 32'h1234_5678;
        repeat (3) @(posedge clkin);
        #1;
        checks++; if (req_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready_out); end
        checks++; if (resp_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", resp_valid_out); end
        checks++; if (resp_err_out !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", resp_err_out); end
        checks++; if (resp_rdata_out !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata_out); end
        checks++; if (mem_wr_en_out !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", mem_wr_en_out); end
        checks++; if (mem_rd_addr_out !== 32'h0 || mem_wr_addr_out !== 32'h0) begin errors++; $display("FAIL reset_addr got %h/%h want 0/0", mem_rd_addr_out, mem_wr_addr_out); end
        checks++; if (mem_wr_data_out !== 32'h0) begin errors++; $display("FAIL reset_wr_data got %h want 0", mem_wr_data_out); end
        @(negedge clkin);
        req_valid_in = 1'b0;
        nrst_in = 1'b1;
        @(posedge clkin); #1;
        checks++; if (req_ready_out !== 1'b1 || resp_valid_out !== 1'b0) begin errors++; $display("FAIL reset_release got rdy=%b vld=%b want 1/0", req_ready_out, resp_valid_out); end
    endtask

    task automatic test_load();
        logic [31:0] a [5];
        logic [2:0]  f [5];
        logic [31:0] e [5];
        int lat, wc, wf; logic [31:0] rd, wa, wd; logic er, va, ra;
        a = '{32'h1, 32'h3, 32'h2, 32'h0, 32'h2};
        f = '{3'd0, 3'd4, 3'd1, 3'd2, 3'd5};
        e = '{32'hFFFF_FFF0, 32'h0000_0080, 32'hFFFF_8070, 32'h8070_F0FF, 32'h0000_8070};
        tb_mem[0] = 32'h8070_F0FF;
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f[i], a[i], 32'h0, lat, rd, er, wc, wf, wa, wd, va, ra);
            checks++; if (rd !== e[i] || er !== 1'b0) begin errors++; $display("FAIL load_%0d data got %h err %b want %h err 0", i, rd, er, e[i]); end
            checks++; if (lat != 2 || wc != 0) begin errors++; $display("FAIL load_%0d timing got lat %0d wr %0d want lat 2 wr 0", i, lat, wc); end
            checks++; if (va !== 1'b0 || ra !== 1'b1) begin errors++; $display("FAIL load_%0d after got vld %b rdy %b want 0 1", i, va, ra); end
        end
    endtask

    task automatic test_store_rmw();
        int lat, wc, wf; logic [31:0] rd, wa, wd; logic er, va, ra;
        tb_mem[0] = 32'h1122_3344;
        do_req(1'b1, 3'd0, 32'h2, 32'hFFFF_FFAB, lat, rd, er, wc, wf, wa, wd, va, ra);
        checks++; if (wc != 1 || wf != 2) begin errors++; $display("FAIL sb_write got count %0d at %0d want 1 at 2", wc, wf); end
        checks++; if (wa !== 32'h0 || wd !== 32'h11AB_3344) begin errors++; $display("FAIL sb_word got %h@%h want 11ab3344@0", wd, wa); end
        checks++; if (lat != 3 || er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sb_resp got lat %0d err %b rdata %h want 3 0 0", lat, er, rd); end
        checks++; if (tb_mem[0] !== 32'h11AB_3344) begin errors++; $display("FAIL sb_mem got %h want 11ab3344", tb_mem[0]); end
        tb_mem[3] = 32'hAAAA_5555;
        do_req(1'b1, 3'd1, 32'hE, 32'h0000_1234, lat, rd, er, wc, wf, wa, wd, va, ra);
        checks++; if (wc != 1 || wa !== 32'h3 || wd !== 32'h1234_5555 || lat != 3) begin errors++; $display("FAIL sh_hi got %h@%h cnt %0d lat %0d want 12345555@3 1 3", wd, wa, wc, lat); end
    endtask

    task automatic test_sw();
        int lat, wc, wf; logic [31:0] rd, wa, wd; logic er, va, ra;
        do_req(1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF, lat, rd, er, wc, wf, wa, wd, va, ra);
        checks++; if (wc != 1 || wf != 1) begin errors++; $display("FAIL sw_write got count %0d at %0d want 1 at 1", wc, wf); end
        checks++; if (wa !== 32'h2 || wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_word got %h@%h want deadbeef@2", wd, wa); end
        checks++; if (lat != 2 || er !== 1'b0) begin errors++; $display("FAIL sw_resp got lat %0d err %b want 2 0", lat, er); end
        checks++; if (tb_mem[2] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_mem got %h want deadbeef", tb_mem[2]); end
    endtask

    task automatic test_misalign();
        int lat, wc, wf; logic [31:0] rd, wa, wd; logic er, va, ra;
        tb_mem[1] = 32'hCAFE_0001;
        do_req(1'b0, 3'd2, 32'h6, 32'h0, lat, rd, er, wc, wf, wa, wd, va, ra);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin errors++; $display("FAIL lw_misalign got err %b rdata %h lat %0d want 1 0 1", er, rd, lat); end
`else
        checks++; if (er !== 1'b0 || rd !== 32'hCAFE_0001 || lat != 2) begin errors++; $display("FAIL lw_misalign got err %b rdata %h lat %0d want 0 cafe0001 2", er, rd, lat); end
`endif
    endtask

    task automatic test_errors();
        int lat, wc, wf; logic [31:0] rd, wa, wd; logic er, va, ra;
        tb_mem[0] = 32'h0BAD_F00D;
        do_req(1'b1, 3'd0, 32'h400, 32'h55, lat, rd, er, wc, wf, wa, wd, va, ra);
        checks++; if (er !== 1'b1 || lat != 1 || wc != 0 || rd !== 32'h0) begin errors++; $display("FAIL err_oob got err %b lat %0d wr %0d rdata %h want 1 1 0 0", er, lat, wc, rd); end
        checks++; if (ra !== 1'b1) begin errors++; $display("FAIL err_oob_ready got %b want 1", ra); end
        do_req(1'b1, 3'd3, 32'h0, 32'hFFFF_FFFF, lat, rd, er, wc, wf, wa, wd, va, ra);
        checks++; if (er !== 1'b1 || lat != 1 || wc != 0) begin errors++; $display("FAIL err_f3_store got err %b lat %0d wr %0d want 1 1 0", er, lat, wc); end
        checks++; if (tb_mem[0] !== 32'h0BAD_F00D) begin errors++; $display("FAIL err_mem got %h want 0badf00d", tb_mem[0]); end
        do_req(1'b0, 3'd6, 32'h0, 32'h0, lat, rd, er, wc, wf, wa, wd, va, ra);
        checks++; if (er !== 1'b1 || lat != 1 || rd !== 32'h0) begin errors++; $display("FAIL err_f3_load got err %b lat %0d rdata %h want 1 1 0", er, lat, rd); end
    endtask

    task automatic test_reset_mid();
        int lat, wc, wf; logic [31:0] rd, wa, wd; logic er, va, ra;
        int bad_wr, bad_vld;
        tb_mem[3] = 32'h0102_0304;
        @(negedge clkin);
        req_valid_in = 1'b1; req_we_in = 1'b1; req_funct3_in = 3'd1;
        req_addr_in = 32'hC; req_wdata_in = 32'h0000_5555;
        @(posedge clkin); #1;
        req_valid_in = 1'b0;
        #2 nrst_in = 1'b0;
        #1;
        checks++; if (mem_wr_en_out !== 1'b0 || req_ready_out !== 1'b1) begin errors++; $display("FAIL rst_mid_async got wr %b rdy %b want 0 1", mem_wr_en_out, req_ready_out); end
        bad_wr = 0; bad_vld = 0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clkin); #1;
            if (mem_wr_en_out) bad_wr++;
            if (resp_valid_out) bad_vld++;
            if (n == 1) nrst_in = 1'b1;
        end
        checks++; if (bad_wr != 0 || bad_vld != 0) begin errors++; $display("FAIL rst_mid_quiet got wr %0d vld %0d want 0 0", bad_wr, bad_vld); end
        checks++; if (tb_mem[3] !== 32'h0102_0304 || req_ready_out !== 1'b1) begin errors++; $display("FAIL rst_mid_mem got %h rdy %b want 01020304 1", tb_mem[3], req_ready_out); end
        do_req(1'b0, 3'd2, 32'hC, 32'h0, lat, rd, er, wc, wf, wa, wd, va, ra);
        checks++; if (rd !== 32'h0102_0304 || er !== 1'b0 || lat != 2) begin errors++; $display("FAIL rst_mid_next got %h err %b lat %0d want 01020304 0 2", rd, er, lat); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
        test_reset();
        test_load();
        test_store_rmw();
        test_sw();
        test_misalign();
        test_errors();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
